wb_tlc_rx_filter: RTL and testbench

- Parametrised receive-side TLP classifier/filter between the PCIe core RX interface and the Wishbone request FIFO.
- Classifies each TLP at its SOP beat as MRd, MWr or, optionally, CplD, and qualifies it against a parametrised BAR mask.
- Drops TLPs on FIFO-full at SOP, rather than writing into a full FIFO.
- Forwards accepted TLPs to the FIFO with fixed 2-cycle latency and keeps saturating drop/overflow/error statistics.

---
 rtl/wb_tlc_rx_filter.sv | 204 ++++++++++++++++++++
 tb/tb_wb_tlc_rx_filter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/wb_tlc_rx_filter.sv
// Receive-side TLP classifier/filter: decodes each TLP at SOP, qualifies it against
// a BAR mask and FIFO space, forwards accepted beats with 2-cycle latency, keeps stats.
module wb_tlc_rx_filter #(
  parameter int          c_DATA_WIDTH = 64,
  parameter logic [6:0]  c_BAR_MASK   = 7'b0000011,
  parameter bit          c_PASS_CPL   = 1'b0,
  parameter int          c_CNT_WIDTH  = 16
) (
  input  logic                    clk_125,
  input  logic                    rstn,
  input  logic [c_DATA_WIDTH-1:0] rx_din,
  input  logic                    rx_sop,
  input  logic                    rx_eop,
  input  logic                    rx_dwen,
  input  logic [6:0]              rx_bar_hit,
  input  logic                    fifo_full,
  input  logic                    clr_cnt,
  output logic [c_DATA_WIDTH-1:0] fifo_dout,
  output logic                    fifo_sop,
  output logic                    fifo_eop,
  output logic                    fifo_dwen,
  output logic                    fifo_wen,
  output logic [6:0]              fifo_bar,
  output logic [1:0]              fifo_type,
  output logic                    fifo_wrn,
  output logic [c_CNT_WIDTH-1:0]  cnt_drop,
  output logic [c_CNT_WIDTH-1:0]  cnt_ovf,
  output logic [c_CNT_WIDTH-1:0]  cnt_err
);

  localparam logic [1:0] TYPE_MRD  = 2'b00;
  localparam logic [1:0] TYPE_MWR  = 2'b01;
  localparam logic [1:0] TYPE_CPLD = 2'b10;
  localparam logic [c_CNT_WIDTH-1:0] CNT_ONE = {{(c_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [c_CNT_WIDTH-1:0] CNT_MAX = {c_CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PASS = 2'b01,
    ST_DROP = 2'b10
  } state_e;

  function automatic logic [c_CNT_WIDTH-1:0] sat_next(
    input logic [c_CNT_WIDTH-1:0] cnt,
    input logic                   inc,
    input logic                   clr
  );
    logic [c_CNT_WIDTH-1:0] res;
    if (clr) begin
      res = '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      res = cnt + CNT_ONE;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  state_e state_q, state_d;

  logic [c_DATA_WIDTH-1:0] s1_dout_q;
  logic                    s1_sop_q, s1_eop_q, s1_dwen_q;
  logic                    s1_wen_q, s1_wen_d;
  logic [6:0]              s1_bar_q, s1_bar_d;
  logic [1:0]              s1_type_q, s1_type_d;

  logic [c_DATA_WIDTH-1:0] out_dout_q;
  logic                    out_sop_q, out_eop_q, out_dwen_q, out_wen_q;
  logic [6:0]              out_bar_q, out_bar_d;
  logic [1:0]              out_type_q, out_type_d;
  logic                    out_wrn_q, out_wrn_d;

  logic [c_CNT_WIDTH-1:0]  cnt_drop_q, cnt_drop_d;
  logic [c_CNT_WIDTH-1:0]  cnt_ovf_q, cnt_ovf_d;
  logic [c_CNT_WIDTH-1:0]  cnt_err_q, cnt_err_d;

  logic [7:0] cmd_s;
  logic       is_mrd_s, is_mwr_s, is_cpld_s;
  logic       supported_s, qualified_s, accept_s, ovf_s;
  logic [1:0] type_s;
  logic       drop_inc_s, ovf_inc_s, err_inc_s;

  // Fmt/Type byte sits in the top byte of header DW0 for every data width.
  assign cmd_s       = rx_din[c_DATA_WIDTH-1 -: 8];
  assign is_mrd_s    = (cmd_s[7:6] == 2'b00) && (cmd_s[4:0] == 5'b00000);
  assign is_mwr_s    = (cmd_s[7:6] == 2'b01) && (cmd_s[4:0] == 5'b00000);
  assign is_cpld_s   = (cmd_s == 8'h4A) && c_PASS_CPL;
  assign supported_s = is_mrd_s || is_mwr_s || is_cpld_s;
  assign qualified_s = (|(rx_bar_hit & c_BAR_MASK)) || is_cpld_s;
  assign accept_s    = supported_s && qualified_s && !fifo_full;
  assign ovf_s       = supported_s && qualified_s && fifo_full;
  assign type_s      = is_mwr_s ? TYPE_MWR : (is_cpld_s ? TYPE_CPLD : TYPE_MRD);

  // Packet state, stage-1 write decision and statistics next-state.
  always_comb begin
    state_d    = state_q;
    s1_wen_d   = 1'b0;
    s1_bar_d   = s1_bar_q;
    s1_type_d  = s1_type_q;
    drop_inc_s = 1'b0;
    ovf_inc_s  = 1'b0;
    err_inc_s  = 1'b0;
    if (rx_sop) begin
      // A new SOP always starts a fresh TLP; any open one is abandoned.
      err_inc_s = (state_q != ST_IDLE);
      if (accept_s) begin
        s1_wen_d  = 1'b1;
        s1_bar_d  = rx_bar_hit;
        s1_type_d = type_s;
        state_d   = rx_eop ? ST_IDLE : ST_PASS;
      end else begin
        ovf_inc_s  = ovf_s;
        drop_inc_s = !ovf_s;
        state_d    = rx_eop ? ST_IDLE : ST_DROP;
      end
    end else begin
      case (state_q)
        ST_PASS: begin
          s1_wen_d = 1'b1;
          if (rx_eop) state_d = ST_IDLE;
          else        state_d = ST_PASS;
        end
        ST_DROP: begin
          if (rx_eop) state_d = ST_IDLE;
          else        state_d = ST_DROP;
        end
        ST_IDLE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    if (s1_sop_q && s1_wen_q) begin
      out_bar_d  = s1_bar_q;
      out_type_d = s1_type_q;
      out_wrn_d  = (s1_type_q == TYPE_MWR);
    end else begin
      out_bar_d  = out_bar_q;
      out_type_d = out_type_q;
      out_wrn_d  = out_wrn_q;
    end

    cnt_drop_d = sat_next(cnt_drop_q, drop_inc_s, clr_cnt);
    cnt_ovf_d  = sat_next(cnt_ovf_q,  ovf_inc_s,  clr_cnt);
    cnt_err_d  = sat_next(cnt_err_q,  err_inc_s,  clr_cnt);
  end

  // Two register stages plus FSM and counter state.
  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      s1_dout_q  <= '0;
      s1_sop_q   <= 1'b0;
      s1_eop_q   <= 1'b0;
      s1_dwen_q  <= 1'b0;
      s1_wen_q   <= 1'b0;
      s1_bar_q   <= 7'd0;
      s1_type_q  <= 2'b00;
      out_dout_q <= '0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      out_dwen_q <= 1'b0;
      out_wen_q  <= 1'b0;
      out_bar_q  <= 7'd0;
      out_type_q <= 2'b00;
      out_wrn_q  <= 1'b0;
      cnt_drop_q <= '0;
      cnt_ovf_q  <= '0;
      cnt_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      s1_dout_q  <= rx_din;
      s1_sop_q   <= rx_sop;
      s1_eop_q   <= rx_eop;
      s1_dwen_q  <= rx_dwen;
      s1_wen_q   <= s1_wen_d;
      s1_bar_q   <= s1_bar_d;
      s1_type_q  <= s1_type_d;
      out_dout_q <= s1_dout_q;
      out_sop_q  <= s1_sop_q;
      out_eop_q  <= s1_eop_q;
      out_dwen_q <= s1_dwen_q;
      out_wen_q  <= s1_wen_q;
      out_bar_q  <= out_bar_d;
      out_type_q <= out_type_d;
      out_wrn_q  <= out_wrn_d;
      cnt_drop_q <= cnt_drop_d;
      cnt_ovf_q  <= cnt_ovf_d;
      cnt_err_q  <= cnt_err_d;
    end
  end

  assign fifo_dout = out_dout_q;
  assign fifo_sop  = out_sop_q;
  assign fifo_eop  = out_eop_q;
  assign fifo_dwen = out_dwen_q;
  assign fifo_wen  = out_wen_q;
  assign fifo_bar  = out_bar_q;
  assign fifo_type = out_type_q;
  assign fifo_wrn  = out_wrn_q;
  assign cnt_drop  = cnt_drop_q;
  assign cnt_ovf   = cnt_ovf_q;
  assign cnt_err   = cnt_err_q;

endmodule

// File: tb/tb_wb_tlc_rx_filter.sv
// Directed bench: two filter instances (CplD blocked / CplD passed) with 4-bit counters,
// checked beat by beat against hand-computed write enables, data and statistics.
module tb_wb_tlc_rx_filter;

  localparam logic [63:0] MWR_H  = 64'h4000_0001_0000_00A0;
  localparam logic [63:0] MWR_H2 = 64'h4000_0002_0000_00B0;
  localparam logic [63:0] MRD_H  = 64'h0000_0001_0000_00C0;
  localparam logic [63:0] CPLD_H = 64'h4A00_0001_0000_00D0;
  localparam logic [63:0] CFG_H  = 64'h0400_0001_0000_00E0;

  logic        clk_125 = 1'b0;
  logic        rstn;
  logic [63:0] rx_din;
  logic        rx_sop, rx_eop, rx_dwen;
  logic [6:0]  rx_bar_hit;
  logic        fifo_full, clr_cnt;

  logic [63:0] fifo_dout0, fifo_dout1;
  logic        fifo_sop0, fifo_sop1, fifo_eop0, fifo_eop1, fifo_dwen0, fifo_dwen1;
  logic        fifo_wen0, fifo_wen1, fifo_wrn0, fifo_wrn1;
  logic [6:0]  fifo_bar0, fifo_bar1;
  logic [1:0]  fifo_type0, fifo_type1;
  logic [3:0]  cnt_drop0, cnt_drop1, cnt_ovf0, cnt_ovf1, cnt_err0, cnt_err1;

  int checks = 0;
  int errors = 0;

  logic [63:0] pd;
  logic        psop, peop, pw0, pw1;

  always #4 clk_125 = ~clk_125;

  wb_tlc_rx_filter #(.c_DATA_WIDTH(64), .c_BAR_MASK(7'b0000011), .c_PASS_CPL(1'b0), .c_CNT_WIDTH(4)) dut0 (
    .clk_125(clk_125), .rstn(rstn), .rx_din(rx_din), .rx_sop(rx_sop), .rx_eop(rx_eop),
    .rx_dwen(rx_dwen), .rx_bar_hit(rx_bar_hit), .fifo_full(fifo_full), .clr_cnt(clr_cnt),
    .fifo_dout(fifo_dout0), .fifo_sop(fifo_sop0), .fifo_eop(fifo_eop0), .fifo_dwen(fifo_dwen0),
    .fifo_wen(fifo_wen0), .fifo_bar(fifo_bar0), .fifo_type(fifo_type0), .fifo_wrn(fifo_wrn0),
    .cnt_drop(cnt_drop0), .cnt_ovf(cnt_ovf0), .cnt_err(cnt_err0));

  wb_tlc_rx_filter #(.c_DATA_WIDTH(64), .c_BAR_MASK(7'b0000011), .c_PASS_CPL(1'b1), .c_CNT_WIDTH(4)) dut1 (
    .clk_125(clk_125), .rstn(rstn), .rx_din(rx_din), .rx_sop(rx_sop), .rx_eop(rx_eop),
    .rx_dwen(rx_dwen), .rx_bar_hit(rx_bar_hit), .fifo_full(fifo_full), .clr_cnt(clr_cnt),
    .fifo_dout(fifo_dout1), .fifo_sop(fifo_sop1), .fifo_eop(fifo_eop1), .fifo_dwen(fifo_dwen1),
    .fifo_wen(fifo_wen1), .fifo_bar(fifo_bar1), .fifo_type(fifo_type1), .fifo_wrn(fifo_wrn1),
    .cnt_drop(cnt_drop1), .cnt_ovf(cnt_ovf1), .cnt_err(cnt_err1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one beat at the falling edge; the beat from the previous call is on the FIFO side now.
  task automatic beat(input logic [63:0] d, input logic sop, input logic eop, input logic [6:0] bar,
                      input logic full, input logic clr, input logic ew0, input logic ew1);
    rx_din = d; rx_sop = sop; rx_eop = eop; rx_dwen = eop;
    rx_bar_hit = bar; fifo_full = full; clr_cnt = clr;
    @(posedge clk_125);
    @(negedge clk_125);
    check("wen0", fifo_wen0, pw0);
    check("wen1", fifo_wen1, pw1);
    check("dout", fifo_dout0, pd);
    check("sop", fifo_sop0, psop);
    check("eop", fifo_eop0, peop);
    check("dwen", fifo_dwen0, peop);
    pd = d; psop = sop; peop = eop; pw0 = ew0; pw1 = ew1;
  endtask

  task automatic idle();
    beat(64'h0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; rx_din = 64'h0; rx_sop = 1'b0; rx_eop = 1'b0; rx_dwen = 1'b0;
    rx_bar_hit = 7'h00; fifo_full = 1'b0; clr_cnt = 1'b0;
    pd = 64'h0; psop = 1'b0; peop = 1'b0; pw0 = 1'b0; pw1 = 1'b0;
    repeat (3) @(negedge clk_125);
    check("rst_wen", fifo_wen0, 1'b0);
    check("rst_type", fifo_type0, 2'b00);
    check("rst_bar", fifo_bar0, 7'h00);
    check("rst_drop", cnt_drop0, 4'h0);
    rstn = 1'b1;
    idle();

    // 3-beat MWr on BAR0
    beat(MWR_H, 1'b1, 1'b0, 7'h01, 1'b0, 1'b0, 1'b1, 1'b1);
    beat(64'h1111_0000_0000_0001, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    beat(64'h2222_0000_0000_0002, 1'b0, 1'b1, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    check("t1_type", fifo_type0, 2'b01);
    check("t1_wrn", fifo_wrn0, 1'b1);
    check("t1_bar", fifo_bar0, 7'h01);
    check("t1_drop", cnt_drop0, 4'h0);
    check("t1_ovf", cnt_ovf0, 4'h0);
    check("t1_err", cnt_err0, 4'h0);

    // MRd hitting only BAR2 (outside mask) is dropped
    beat(MRD_H, 1'b1, 1'b0, 7'h04, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(64'h3333_0000_0000_0003, 1'b0, 1'b1, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_drop", cnt_drop0, 4'h1);
    idle();

    // MRd on BAR1 with FIFO full, then back-to-back MWr forwarded
    beat(MRD_H, 1'b1, 1'b0, 7'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    beat(64'h4444_0000_0000_0004, 1'b0, 1'b1, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(MWR_H2, 1'b1, 1'b0, 7'h02, 1'b0, 1'b0, 1'b1, 1'b1);
    beat(64'h5555_0000_0000_0005, 1'b0, 1'b1, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    check("t3_ovf", cnt_ovf0, 4'h1);
    check("t3_drop", cnt_drop0, 4'h1);
    check("t3_bar", fifo_bar0, 7'h02);

    // Single-beat CplD without BAR hit: dropped by dut0, forwarded by dut1
    beat(CPLD_H, 1'b1, 1'b1, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    check("t4_drop0", cnt_drop0, 4'h2);
    check("t4_drop1", cnt_drop1, 4'h1);
    check("t4_type1", fifo_type1, 2'b10);
    check("t4_wrn1", fifo_wrn1, 1'b0);
    check("t4_bar1", fifo_bar1, 7'h00);
    check("t4_type0", fifo_type0, 2'b01);

    // SOP inside an open MWr: error counted, new TLP forwarded from its SOP
    beat(MWR_H, 1'b1, 1'b0, 7'h01, 1'b0, 1'b0, 1'b1, 1'b1);
    beat(64'h6666_0000_0000_0006, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    beat(MWR_H2, 1'b1, 1'b0, 7'h01, 1'b0, 1'b0, 1'b1, 1'b1);
    beat(64'h7777_0000_0000_0007, 1'b0, 1'b1, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    check("t5_err0", cnt_err0, 4'h1);
    check("t5_err1", cnt_err1, 4'h1);

    // Unsupported Cfg type on BAR0, then a stray EOP in IDLE
    beat(CFG_H, 1'b1, 1'b1, 7'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(64'h8888_0000_0000_0008, 1'b0, 1'b1, 7'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    check("t6_drop0", cnt_drop0, 4'h3);
    check("t6_drop1", cnt_drop1, 4'h2);
    check("t6_ovf", cnt_ovf0, 4'h1);

    // 2^4+3 BAR-miss TLPs saturate the drop counter
    for (int i = 0; i < 19; i++) begin
      beat(MRD_H, 1'b1, 1'b1, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("sat_drop0", cnt_drop0, 4'hF);
    check("sat_drop1", cnt_drop1, 4'hF);
    beat(MRD_H, 1'b1, 1'b1, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    check("clr_drop0", cnt_drop0, 4'h0);
    check("clr_ovf0", cnt_ovf0, 4'h0);
    check("clr_err0", cnt_err0, 4'h0);
    check("clr_drop1", cnt_drop1, 4'h0);

    // Reset in the middle of an accepted TLP
    beat(MWR_H, 1'b1, 1'b0, 7'h02, 1'b0, 1'b0, 1'b1, 1'b1);
    rx_din = 64'h9999_0000_0000_0009; rx_sop = 1'b0; rx_eop = 1'b0; rx_dwen = 1'b0;
    @(posedge clk_125);
    @(negedge clk_125);
    check("mid_wen", fifo_wen0, 1'b1);
    check("mid_bar", fifo_bar0, 7'h02);
    rstn = 1'b0;
    #1;
    check("arst_wen", fifo_wen0, 1'b0);
    check("arst_dout", fifo_dout0, 64'h0);
    check("arst_sop", fifo_sop0, 1'b0);
    check("arst_type", fifo_type0, 2'b00);
    check("arst_bar", fifo_bar0, 7'h00);
    rx_din = 64'h0;
    @(negedge clk_125);
    rstn = 1'b1;
    pd = 64'h0; psop = 1'b0; peop = 1'b0; pw0 = 1'b0; pw1 = 1'b0;
    beat(MWR_H2, 1'b1, 1'b1, 7'h01, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    check("post_type", fifo_type0, 2'b01);
    check("post_wrn", fifo_wrn0, 1'b1);
    check("post_bar", fifo_bar0, 7'h01);
    check("post_err", cnt_err0, 4'h0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
